// File: rtl/ttl74x521_seq_cmp_if.sv
// Bus bundle for the ttl74x521_seq_cmp sequence comparator.
// WM exists only when TTL521_MASK_EN is defined.
interface ttl74x521_seq_cmp_if #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic             G_n;
    logic             STB;
    logic [WIDTH-1:0] P;
    logic             WE;
    logic [AW-1:0]    WA;
    logic [WIDTH-1:0] WD;
`ifdef TTL521_MASK_EN
    logic [WIDTH-1:0] WM;
`endif
    logic             EQ_n;
    logic             P_n;
    logic [CW-1:0]    IDX;

    modport master (
`ifdef TTL521_MASK_EN
        output WM,
`endif
        output G_n, STB, P, WE, WA, WD,
        input  EQ_n, P_n, IDX
    );

    modport slave (
`ifdef TTL521_MASK_EN
        input  WM,
`endif
        input  G_n, STB, P, WE, WA, WD,
        output EQ_n, P_n, IDX
    );
endinterface

// File: rtl/ttl74x521_seq_cmp.sv
// Clocked sequence comparator: matches a strobed word stream against a DEPTH-entry table.
// Optional don't-care masks per entry via TTL521_MASK_EN.
module ttl74x521_seq_cmp #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input logic                CLK,
    input logic                CLR,
    ttl74x521_seq_cmp_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] LAST = CW'(DEPTH - 1);

    logic [WIDTH-1:0] pat [DEPTH];
`ifdef TTL521_MASK_EN
    logic [WIDTH-1:0] msk [DEPTH];
`endif

    logic [CW-1:0]    idx, idx_nxt;
    logic             eq_n_q, p_n_q, eq_n_nxt, p_n_nxt;
    logic             accept, hit_cur, hit_zero, wr_ok;
    logic [WIDTH-1:0] care_cur, care_zero;

    // Compares read the table as it stood before this edge.
    always_comb begin
`ifdef TTL521_MASK_EN
        care_cur  = ~msk[idx[AW-1:0]];
        care_zero = ~msk[0];
`else
        care_cur  = '1;
        care_zero = '1;
`endif
        hit_cur  = ((bus.P ^ pat[idx[AW-1:0]]) & care_cur) == '0;
        hit_zero = ((bus.P ^ pat[0]) & care_zero) == '0;
        accept   = bus.STB & ~bus.G_n & ~bus.WE;
        wr_ok    = int'(bus.WA) < DEPTH;
    end

    always_ff @(posedge CLK or posedge CLR) begin
        if (CLR) begin
            pat <= '{default: '0};
`ifdef TTL521_MASK_EN
            msk <= '{default: '0};
`endif
        end else if (bus.WE && wr_ok) begin
            pat[bus.WA] <= bus.WD;
`ifdef TTL521_MASK_EN
            msk[bus.WA] <= bus.WM;
`endif
        end
    end

    always_ff @(posedge CLK or posedge CLR) begin
        if (CLR) begin
            idx    <= '0;
            eq_n_q <= 1'b1;
            p_n_q  <= 1'b1;
        end else begin
            idx    <= idx_nxt;
            eq_n_q <= eq_n_nxt;
            p_n_q  <= p_n_nxt;
        end
    end

    // A miss that matches entry 0 restarts tracking at 1 rather than dropping to idle.
    always_comb begin
        idx_nxt = idx;
        if (bus.WE) begin
            idx_nxt = '0;
        end else if (accept) begin
            if (hit_cur)
                idx_nxt = (idx == LAST) ? '0 : idx + CW'(1);
            else
                idx_nxt = hit_zero ? CW'(1) : '0;
        end
    end

    always_comb begin
        eq_n_nxt = ~(accept & hit_cur);
        p_n_nxt  = ~(accept & hit_cur & (idx == LAST));
    end

    assign bus.EQ_n = eq_n_q;
    assign bus.P_n  = p_n_q;
    assign bus.IDX  = idx;
endmodule

// File: tb/tb_ttl74x521_seq_cmp.sv
// Self-checking bench for ttl74x521_seq_cmp: directed scenarios plus random stream vs a reference model.
// Define TTL521_MASK_EN to also exercise the don't-care masks.
module tb_ttl74x521_seq_cmp;
    localparam int WIDTH = 8;
    localparam int DEPTH = 4;
    localparam int AW = $clog2(DEPTH);

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   failures = 0;

    ttl74x521_seq_cmp_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

    ttl74x521_seq_cmp #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .CLK (clk),
        .CLR (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Reference model: progress count and expected output levels.
    logic [WIDTH-1:0] pat_m [DEPTH];
    logic [WIDTH-1:0] msk_m [DEPTH];
    int               m_idx;
    logic             m_eq_n, m_p_n;

    function automatic bit word_hit(input logic [WIDTH-1:0] w, input int i);
        return ((w ^ pat_m[i]) & ~msk_m[i]) == 0;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) begin
            pat_m[i] = '0;
            msk_m[i] = '0;
        end
        m_idx  = 0;
        m_eq_n = 1'b1;
        m_p_n  = 1'b1;
    endtask

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic check_outputs(input string tag);
        chk({tag, ".EQ_n"}, int'(bus.EQ_n), int'(m_eq_n));
        chk({tag, ".P_n"},  int'(bus.P_n),  int'(m_p_n));
        chk({tag, ".IDX"},  int'(bus.IDX),  m_idx);
    endtask

    task automatic idle_inputs();
        bus.G_n = 1'b0;
        bus.STB = 1'b0;
        bus.P   = '0;
        bus.WE  = 1'b0;
        bus.WA  = '0;
        bus.WD  = '0;
`ifdef TTL521_MASK_EN
        bus.WM  = '0;
`endif
    endtask

    // One clock: drive, advance the model from the pre-edge state, then check.
    task automatic step(input string tag, input logic g_n, input logic stb,
                        input logic [WIDTH-1:0] p, input logic we, input int wa,
                        input logic [WIDTH-1:0] wd, input logic [WIDTH-1:0] wm);
        bit h;
        bus.G_n = g_n;
        bus.STB = stb;
        bus.P   = p;
        bus.WE  = we;
        bus.WA  = AW'(wa);
        bus.WD  = wd;
`ifdef TTL521_MASK_EN
        bus.WM  = wm;
`endif
        @(posedge clk);
        m_eq_n = 1'b1;
        m_p_n  = 1'b1;
        if (we) begin
            m_idx = 0;
            if (wa < DEPTH) begin
                pat_m[wa] = wd;
`ifdef TTL521_MASK_EN
                msk_m[wa] = wm;
`endif
            end
        end else if (stb && !g_n) begin
            h = word_hit(p, m_idx);
            if (h) begin
                m_eq_n = 1'b0;
                if (m_idx == DEPTH - 1) begin
                    m_idx = 0;
                    m_p_n = 1'b0;
                end else begin
                    m_idx++;
                end
            end else begin
                m_idx = word_hit(p, 0) ? 1 : 0;
            end
        end
        #1;
        check_outputs(tag);
    endtask

    task automatic word(input string tag, input logic [WIDTH-1:0] p);
        step(tag, 1'b0, 1'b1, p, 1'b0, 0, '0, '0);
    endtask

    task automatic idle(input string tag);
        step(tag, 1'b0, 1'b0, '0, 1'b0, 0, '0, '0);
    endtask

    task automatic write_pat(input int wa, input logic [WIDTH-1:0] wd, input logic [WIDTH-1:0] wm);
        step("wr", 1'b0, 1'b0, '0, 1'b1, wa, wd, wm);
    endtask

    task automatic load_default();
        write_pat(0, 8'hA5, '0);
        write_pat(1, 8'h3C, '0);
        write_pat(2, 8'hFF, '0);
        write_pat(3, 8'h00, '0);
    endtask

    initial begin
        logic [WIDTH-1:0] p, wd;
        logic g_n, stb, we;
        int wa;

        idle_inputs();
        model_reset();
        #12;
        check_outputs("por");
        @(negedge clk);
        rst = 1'b0;

        // Full sequence match
        load_default();
        word("m_a5", 8'hA5);
        word("m_3c", 8'h3C);
        word("m_ff", 8'hFF);
        word("m_00", 8'h00);
        idle("m_after");

        // Miss that restarts at entry 0
        word("r_a5", 8'hA5);
        word("r_3c", 8'h3C);
        word("r_a5b", 8'hA5);
        word("r_3cb", 8'h3C);
        word("r_ff", 8'hFF);
        word("r_00", 8'h00);
        idle("r_after");

        // Disable holds progress
        word("g_a5", 8'hA5);
        word("g_3c", 8'h3C);
        for (int i = 0; i < 3; i++)
            step("g_off", 1'b1, 1'b1, 8'hFF, 1'b0, 0, '0, '0);
        word("g_ff", 8'hFF);
        word("g_00", 8'h00);
        idle("g_after");

        // Write colliding with a strobe
        word("w_a5", 8'hA5);
        word("w_3c", 8'h3C);
        step("w_coll", 1'b0, 1'b1, 8'hFF, 1'b1, 2, 8'h77, '0);
        word("w2_a5", 8'hA5);
        word("w2_3c", 8'h3C);
        word("w2_77", 8'h77);
        word("w2_00", 8'h00);
        write_pat(2, 8'hFF, '0);

        // Asynchronous reset mid-sequence
        word("c_a5", 8'hA5);
        word("c_3c", 8'h3C);
        chk("c_idx2", int'(bus.IDX), 2);
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        check_outputs("clr_async");
        idle_inputs();
        @(negedge clk);
        rst = 1'b0;
        word("c_cleared", 8'h00);
        idle("c_idle");
        load_default();

`ifdef TTL521_MASK_EN
        write_pat(0, 8'hA0, 8'h0F);
        word("k_a7", 8'hA7);
        word("k_b0", 8'hB0);
        write_pat(0, 8'hA5, '0);
`endif

        // Random stream against the model
        for (int n = 0; n < 400; n++) begin
            g_n = ($urandom_range(0, 9) == 0);
            stb = ($urandom_range(0, 9) < 7);
            we  = ($urandom_range(0, 24) == 0);
            wa  = $urandom_range(0, DEPTH - 1);
            wd  = ($urandom_range(0, 1) == 0) ? WIDTH'($urandom) : pat_m[$urandom_range(0, DEPTH - 1)];
            p   = ($urandom_range(0, 3) == 0) ? WIDTH'($urandom) : pat_m[$urandom_range(0, DEPTH - 1)];
            step("rnd", g_n, stb, p, we, wa, wd, WIDTH'($urandom) & WIDTH'($urandom));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
